alu_mc: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Accepts one operation per valid/ready handshake and holds an architectural NZCV flag register.
- Adds carry-in ops (ADC/SBC), true saturating add and an iterative multiplier with early termination.
- Sits between operand fetch/shifter and writeback; result and flags are presented on a valid/ready output port.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_iter.sv | 66 ++++++
 rtl/alu_mc.sv | 183 ++++++++++++++++++
 tb/tb_alu_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    // Opcode encodings inherited from the combinational ALU
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_QADD = 4'b0010;
    localparam logic [3:0] ALU_SBC  = 4'b0011;
    localparam logic [3:0] ALU_CMP  = 4'b0100;
    localparam logic [3:0] ALU_ADC  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_ORR  = 4'b1000;
    localparam logic [3:0] ALU_EOR  = 4'b1001;
    localparam logic [3:0] ALU_MVN  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;

    // Positions inside the {N,Z,C,V} flag register
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned multiplier retiring MUL_STEP multiplier bits per cycle,
// stopping as soon as the remaining multiplier bits are all zero.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (aborts any product in flight)
//   start      : load a/b and begin iterating (next cycle is the first iteration)
//   a, b       : multiplicand, multiplier
//   done       : high in the cycle whose iteration produces the final product
//   product    : low WIDTH bits of a*b, valid while done is high
module alu_mul_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned NCHUNK = WIDTH / MUL_STEP;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic             running;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] b_next;
    logic [CW-1:0]    iter;

    // One iteration: add multiplicand times the lowest remaining chunk
    always_comb begin
        partial = a_sh * WIDTH'(b_rem[MUL_STEP-1:0]);
        product = acc + partial;
        b_next  = b_rem >> MUL_STEP;
        // Iteration count is a backstop; b_next reaches zero by the last chunk anyway
        done    = running && ((b_next == '0) || (iter == CW'(NCHUNK - 1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            a_sh    <= '0;
            b_rem   <= '0;
            acc     <= '0;
            iter    <= '0;
        end else if (start) begin
            running <= 1'b1;
            a_sh    <= a;
            b_rem   <= b;
            acc     <= '0;
            iter    <= '0;
        end else if (running) begin
            acc   <= product;
            a_sh  <= a_sh << MUL_STEP;
            b_rem <= b_next;
            iter  <= iter + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with NZCV flag register, carry-in ops, saturating
// add and an early-terminating iterative multiplier.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake (one op per accept)
//   alu_control         : opcode
//   set_flags           : write NZCV from this op (CMP always writes)
//   operand_a/operand_b : operands (operand_b is the multiplier for MUL)
//   out_valid, out_ready: result handshake
//   result, illegal_op  : registered result, set when the opcode was unused
//   flags               : architectural {N,Z,C,V}
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal_op
);

    localparam int unsigned SW = WIDTH + 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_set_flags;
    logic [3:0]       mul_flags;

    logic             sub_op;
    logic             cin;
    logic [WIDTH-1:0] b_op;
    logic [SW-1:0]    sum;
    logic             ovf;
    logic             wr_arith;
    logic             wr_nz;
    logic [WIDTH-1:0] dp_result;
    logic             dp_illegal;
    logic [3:0]       dp_flags;

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (operand_a),
        .b       (operand_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath: one shared WIDTH+1 adder for all add/subtract ops
    always_comb begin
        sub_op     = (alu_control == ALU_SUB) || (alu_control == ALU_SBC) || (alu_control == ALU_CMP);
        b_op       = sub_op ? ~operand_b : operand_b;
        cin        = 1'b0;
        if ((alu_control == ALU_SUB) || (alu_control == ALU_CMP)) begin
            cin = 1'b1;
        end else if ((alu_control == ALU_SBC) || (alu_control == ALU_ADC)) begin
            cin = flags[FLAG_C];
        end
        sum        = {1'b0, operand_a} + {1'b0, b_op} + SW'(cin);
        ovf        = (operand_a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);

        dp_result  = '0;
        dp_illegal = 1'b0;
        wr_arith   = 1'b0;
        wr_nz      = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_SUB, ALU_SBC, ALU_ADC: begin
                dp_result = sum[WIDTH-1:0];
                wr_arith  = set_flags;
            end
            ALU_CMP: begin
                dp_result = sum[WIDTH-1:0];
                wr_arith  = 1'b1;
            end
            ALU_QADD: begin
                dp_result = ovf ? (operand_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
                wr_arith  = set_flags;
            end
            ALU_AND: begin dp_result = operand_a & operand_b; wr_nz = set_flags; end
            ALU_ORR: begin dp_result = operand_a | operand_b; wr_nz = set_flags; end
            ALU_EOR: begin dp_result = operand_a ^ operand_b; wr_nz = set_flags; end
            ALU_MVN: begin dp_result = ~operand_a;            wr_nz = set_flags; end
            ALU_MUL: dp_result = '0;
            default: dp_illegal = 1'b1;
        endcase

        dp_flags = flags;
        if (wr_arith || wr_nz) begin
            dp_flags[FLAG_N] = dp_result[WIDTH-1];
            dp_flags[FLAG_Z] = (dp_result == '0);
        end
        if (wr_arith) begin
            dp_flags[FLAG_C] = sum[WIDTH];
            dp_flags[FLAG_V] = ovf;
        end

        mul_flags = flags;
        if (mul_set_flags) begin
            mul_flags[FLAG_N] = mul_product[WIDTH-1];
            mul_flags[FLAG_Z] = (mul_product == '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mul_start) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake and multiplier launch
    always_comb begin
        in_ready  = (state == IDLE) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        is_mul    = (alu_control == ALU_MUL);
        mul_start = accept && is_mul;
    end

    // Output and flag registers; a retiring result and a new load may share an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            result        <= '0;
            flags         <= '0;
            illegal_op    <= 1'b0;
            mul_set_flags <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !is_mul) begin
                out_valid  <= 1'b1;
                result     <= dp_result;
                illegal_op <= dp_illegal;
                flags      <= dp_flags;
            end
            if (mul_start) begin
                mul_set_flags <= set_flags;
            end
            if ((state == MUL_BUSY) && mul_done) begin
                out_valid  <= 1'b1;
                result     <= mul_product;
                illegal_op <= 1'b0;
                flags      <= mul_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32, MUL_STEP=8): directed plan steps
// followed by random ops checked against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic        set_flags;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;
    logic [3:0] m_flags;

    alu_mc #(.WIDTH(32), .MUL_STEP(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .set_flags   (set_flags),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: flags from signed/unsigned integer ranges, latency from multiplier chunks
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic sf, input logic [3:0] fl,
                                  output logic [31:0] res, output logic ill,
                                  output logic [3:0] fl_out, output int lat);
        longint unsigned ua, ub, full, bw;
        longint sa, sb, sr;
        logic c, v, arith, wr_all, wr_nz;
        ua = 64'(a); ub = 64'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sr = 0; c = fl[1]; v = fl[0];
        arith = 1'b0; wr_all = 1'b0; wr_nz = 1'b0;
        ill = 1'b0; lat = 1; res = '0;
        case (op)
            4'h0: begin full = ua + ub; res = full[31:0]; c = full[32]; sr = sa + sb; arith = 1'b1; wr_all = sf; end
            4'h5: begin full = ua + ub + 64'(fl[1]); res = full[31:0]; c = full[32];
                        sr = sa + sb + longint'(fl[1]); arith = 1'b1; wr_all = sf; end
            4'h1, 4'h4: begin res = 32'(ua - ub); c = (ua >= ub); sr = sa - sb; arith = 1'b1;
                        wr_all = sf || (op == 4'h4); end
            4'h3: begin bw = 64'(!fl[1]); res = 32'(ua - ub - bw); c = (ua >= ub + bw);
                        sr = sa - sb - longint'(bw); arith = 1'b1; wr_all = sf; end
            4'h2: begin
                full = ua + ub; c = full[32]; sr = sa + sb; arith = 1'b1; wr_all = sf;
                if (sr > 64'sd2147483647)       res = 32'h7FFF_FFFF;
                else if (sr < -64'sd2147483648) res = 32'h8000_0000;
                else                            res = 32'(sr);
            end
            4'h7: begin res = a & b; wr_nz = sf; end
            4'h8: begin res = a | b; wr_nz = sf; end
            4'h9: begin res = a ^ b; wr_nz = sf; end
            4'hA: begin res = ~a;    wr_nz = sf; end
            4'hB: begin
                res = 32'(ua * ub); wr_nz = sf; lat = 2;
                for (int i = 1; i < 4; i++) if (b[8*i +: 8] != 8'h00) lat = i + 2;
            end
            default: ill = 1'b1;
        endcase
        if (arith) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        fl_out = fl;
        if (wr_all) fl_out = {res[31], (res == 32'h0), c, v};
        else if (wr_nz) begin fl_out[3] = res[31]; fl_out[2] = (res == 32'h0); end
    endfunction

    // Issue one op with out_ready high, check result, flags, latency and busy cycles
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic sf, input string tag);
        logic [31:0] eres; logic eill; logic [3:0] efl; int elat;
        int n; int lat; int busy;
        model(op, a, b, sf, m_flags, eres, eill, efl, elat);
        alu_control = op; operand_a = a; operand_b = b; set_flags = sf; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; busy = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},   64'(lat),        64'(elat));
        chk({tag, "_busy"},  64'(busy),       64'(elat - 1));
        chk({tag, "_res"},   64'(result),     64'(eres));
        chk({tag, "_ill"},   64'(illegal_op), 64'(eill));
        chk({tag, "_flags"}, 64'(flags),      64'(efl));
        m_flags = efl;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] eres; logic eill; logic [3:0] efl; int elat;
        logic [3:0] op; logic [31:0] a; logic [31:0] b;

        rst_n = 1'b0; in_valid = 1'b0; alu_control = 4'h0; set_flags = 1'b0;
        operand_a = '0; operand_b = '0; out_ready = 1'b1; m_flags = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),   64'(1));
        chk("rst_out_valid", 64'(out_valid),  64'(0));
        chk("rst_result",    64'(result),     64'(0));
        chk("rst_flags",     64'(flags),      64'(0));
        chk("rst_illegal",   64'(illegal_op), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Plan 1: signed overflow on ADD
        run_op(4'h0, 32'h7FFF_FFFF, 32'h1, 1'b1, "add_ovf");
        chk("add_ovf_const", 64'({result, flags}), 64'({32'h8000_0000, 4'b1001}));

        // Plan 2: saturation both directions
        run_op(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b1, "qadd_pos");
        chk("qadd_pos_const", 64'({result, flags[0]}), 64'({32'h7FFF_FFFF, 1'b1}));
        run_op(4'h2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "qadd_neg");
        chk("qadd_neg_const", 64'({result, flags}), 64'({32'h8000_0000, 4'b1011}));

        // Plan 3: carry chaining through SUB/ADC/SBC
        run_op(4'h1, 32'd5, 32'd5, 1'b1, "sub_eq");
        chk("sub_eq_const", 64'({result, flags}), 64'({32'h0, 4'b0110}));
        run_op(4'h5, 32'd1, 32'd1, 1'b1, "adc");
        chk("adc_const", 64'(result), 64'(3));
        run_op(4'h1, 32'd0, 32'd1, 1'b1, "sub_borrow");
        run_op(4'h3, 32'd0, 32'd0, 1'b1, "sbc");
        chk("sbc_const", 64'({result, flags[3]}), 64'({32'hFFFF_FFFF, 1'b1}));

        // Plan 4: multiplier early termination and full length
        run_op(4'hB, 32'h0001_0000, 32'h3, 1'b1, "mul_short");
        chk("mul_short_const", 64'(result), 64'(32'h0003_0000));
        run_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mul_long");
        chk("mul_long_const", 64'(result), 64'(1));

        // Back-to-back: ADC must see the carry set by the ADD accepted just before
        model(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b1, m_flags, eres, eill, efl, elat);
        m_flags = efl;
        alu_control = 4'h0; operand_a = 32'hFFFF_FFFF; operand_b = 32'h1; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b2b_add_res", 64'({out_valid, result}), 64'({1'b1, eres}));
        model(4'h5, 32'd1, 32'd1, 1'b1, m_flags, eres, eill, efl, elat);
        m_flags = efl;
        alu_control = 4'h5; operand_a = 32'd1; operand_b = 32'd1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_adc_res",   64'({out_valid, result}), 64'({1'b1, eres}));
        chk("b2b_adc_flags", 64'(flags), 64'(efl));
        chk("b2b_adc_const", 64'(result), 64'(3));
        @(negedge clk);

        // Plan 5: output stall holds result and blocks a pending request
        out_ready = 1'b0;
        run_op(4'h7, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, "and_hold");
        model(4'h8, 32'h1234_0000, 32'h0000_5678, 1'b1, m_flags, eres, eill, efl, elat);
        alu_control = 4'h8; operand_a = 32'h1234_0000; operand_b = 32'h0000_5678; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_res",   64'({out_valid, result}), 64'({1'b1, 32'h0000_00F0}));
            chk("hold_ready", 64'(in_ready), 64'(0));
            chk("hold_flags", 64'(flags), 64'(m_flags));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("hold_next_res",   64'({out_valid, result}), 64'({1'b1, eres}));
        chk("hold_next_flags", 64'(flags), 64'(efl));
        m_flags = efl;
        @(negedge clk);

        // Plan 6: reset during the second multiplier iteration
        alu_control = 4'hB; operand_a = 32'h1234_5678; operand_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_flags",     64'(flags),     64'(0));
        chk("mrst_in_ready",  64'(in_ready),  64'(1));
        m_flags = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'h0, 32'd2, 32'd3, 1'b1, "add_after_rst");
        chk("add_after_rst_const", 64'(result), 64'(5));

        // Plan 7: unused opcode leaves flags alone
        run_op(4'h1, 32'd0, 32'd1, 1'b1, "pre_ill");
        run_op(4'h6, 32'hDEAD_BEEF, 32'h1, 1'b1, "illegal");
        chk("illegal_const", 64'({result, illegal_op, flags}), 64'({32'h0, 1'b1, 4'b1000}));

        // Random ops against the model
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = (op == 4'hB) ? ($urandom >> $urandom_range(0, 31)) : pick();
            run_op(op, a, b, 1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
